// File: rtl/instruction_encoder.sv
// RV32I instruction word assembler with address counter and small output FIFO.
// Optional immediate range/alignment checking is enabled by defining ENCODER_IMM_CHECK_EN.
module instruction_encoder #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err,
    output logic                  err_sticky
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);

    function automatic logic [31:0] encode_word(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            3'd0:    w = {f7, rs2, rs1, f3, rd, op};
            3'd1:    w = {imm[11:0], rs1, f3, rd, op};
            3'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            3'd3:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            3'd4:    w = {imm[31:12], rd, op};
            3'd5:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

`ifdef ENCODER_IMM_CHECK_EN
    function automatic logic imm_in_range(input logic [2:0] fmt, input logic [31:0] imm);
        logic ok;
        case (fmt)
            3'd1, 3'd2: ok = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
            3'd3:       ok = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
            3'd4:       ok = (imm[11:0] == 12'h000);
            3'd5:       ok = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction
`endif

    logic [31:0]           mem_inst_r [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  out_valid_r;
    logic                  err_r;
    logic                  err_sticky_r;
    logic [31:0]           enc_s;
    logic                  fmt_ok_s;
    logic                  imm_ok_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  reject_s;
    logic                  pop_s;

    // Legality of the presented field set
    always_comb begin
        fmt_ok_s = (in_fmt <= 3'd5);
`ifdef ENCODER_IMM_CHECK_EN
        imm_ok_s = imm_in_range(in_fmt, in_imm);
`else
        imm_ok_s = 1'b1;
`endif
    end

    // Handshake decode and FIFO occupancy update
    always_comb begin
        enc_s      = encode_word(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
        in_ready_s = (count_r < DEPTH_C) && !restart;
        accept_s   = in_valid && in_ready_s;
        push_s     = accept_s && fmt_ok_s && imm_ok_s;
        reject_s   = accept_s && !(fmt_ok_s && imm_ok_s);
        pop_s      = out_valid_r && out_ready && !restart;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage, pointers, address counter and error flags; restart outranks traffic
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_inst_r[i] <= 32'h0000_0000;
                mem_addr_r[i] <= BASE_A;
            end
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            addr_r       <= BASE_A;
            out_valid_r  <= 1'b0;
            err_r        <= 1'b0;
            err_sticky_r <= 1'b0;
        end else if (restart) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            addr_r       <= BASE_A;
            out_valid_r  <= 1'b0;
            err_r        <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_inst_r[wr_ptr_r] <= enc_s;
                mem_addr_r[wr_ptr_r] <= addr_r;
                wr_ptr_r             <= next_ptr(wr_ptr_r);
                addr_r               <= addr_r + ADDR_STEP;
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            err_r       <= reject_s;
            if (reject_s) begin
                err_sticky_r <= 1'b1;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_inst   = mem_inst_r[rd_ptr_r];
    assign out_addr   = mem_addr_r[rd_ptr_r];
    assign err        = err_r;
    assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed plan items plus randomized traffic
// against a queue-based reference model.
module tb_instruction_encoder;

    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          restart;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [6:0]    in_opcode;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_addr;
    logic          err;
    logic          err_sticky;

    instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .err(err), .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_addr;
    logic        m_err;
    logic        m_sticky;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [63:0] mask;
        mask = (64'h1 << (hi - lo + 1)) - 64'h1;
        return 32'((64'(v) >> lo) & mask);
    endfunction

    // Instruction word built as a weighted sum of fields at their bit positions
    function automatic logic [31:0] ref_encode(input int fmt, input logic [31:0] op,
        input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] rd,
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        case (fmt)
            0: return op + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 33554432;
            1: return op + rd * 128 + f3 * 4096 + rs1 * 32768 + fld(imm, 11, 0) * 1048576;
            2: return op + fld(imm, 4, 0) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
                      + fld(imm, 11, 5) * 33554432;
            3: return op + fld(imm, 11, 11) * 128 + fld(imm, 4, 1) * 256 + f3 * 4096 + rs1 * 32768
                      + rs2 * 1048576 + fld(imm, 10, 5) * 33554432 + fld(imm, 12, 12) * 32'h8000_0000;
            4: return op + rd * 128 + (imm & 32'hFFFF_F000);
            5: return op + rd * 128 + fld(imm, 19, 12) * 4096 + fld(imm, 11, 11) * 1048576
                      + fld(imm, 10, 1) * 2097152 + fld(imm, 20, 20) * 32'h8000_0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input int fmt, input logic [31:0] imm);
        int s;
        s = imm;
        if (fmt > 5) return 1'b0;
`ifdef ENCODER_IMM_CHECK_EN
        if (fmt == 1 || fmt == 2) return (s >= -2048) && (s <= 2047);
        if (fmt == 3) return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        if (fmt == 4) return (imm % 4096) == 0;
        if (fmt == 5) return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
`else
        if (s == 0) return 1'b1;
`endif
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit pop;
        bit acc;
        entry_t e;
        if (restart) begin
            q.delete();
            m_addr   = BASE;
            m_err    = 1'b0;
            m_sticky = 1'b0;
        end else begin
            pop   = (q.size() > 0) && out_ready;
            acc   = in_valid && (q.size() < DEPTH);
            m_err = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (ref_legal(int'(in_fmt), in_imm)) begin
                    e.inst = ref_encode(int'(in_fmt), 32'(in_opcode), 32'(in_funct3), 32'(in_funct7),
                                        32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
                    e.addr = m_addr;
                    q.push_back(e);
                    m_addr = m_addr + 32'd4;
                end else begin
                    m_err    = 1'b1;
                    m_sticky = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_inst", out_inst, q[0].inst);
            check("out_addr", out_addr, q[0].addr);
        end
        check("err", 32'(err), 32'(m_err));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic cycle();
        #1;
        check("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && (restart == 1'b0)));
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic drive(input int fmt, input int op, input int f3, input int f7,
                         input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = 3'(fmt);
        in_opcode = 7'(op);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_imm    = imm;
    endtask

    task automatic model_reset();
        q.delete();
        m_addr   = BASE;
        m_err    = 1'b0;
        m_sticky = 1'b0;
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_err", 32'(err), 32'h0);
        check("rst_err_sticky", 32'(err_sticky), 32'h0);
        reset = 1'b0;

        // Plan 1: single I-type
        drive(1, 8'h13, 0, 0, 1, 0, 0, 32'd5);
        cycle();
        check("t1_inst", out_inst, 32'h0050_0093);
        check("t1_addr", out_addr, 32'h0);
        in_valid = 1'b0; restart = 1'b1;
        cycle();
        restart = 1'b0;

        // Plans 2 and 3: back-to-back R, S, B, U, J with the consumer always ready
        drive(0, 8'h33, 0, 0, 3, 1, 2, 32'h0);          cycle(); check("t2_r", out_inst, 32'h0020_81B3);
        check("t2_r_addr", out_addr, 32'h0);
        drive(2, 8'h23, 2, 0, 0, 1, 2, 32'd8);          cycle(); check("t2_s", out_inst, 32'h0020_A423);
        check("t2_s_addr", out_addr, 32'h4);
        drive(3, 8'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);  cycle(); check("t2_b", out_inst, 32'hFE00_0EE3);
        check("t2_b_addr", out_addr, 32'h8);
        drive(4, 8'h37, 0, 0, 5, 0, 0, 32'h1234_5000);  cycle(); check("t3_u", out_inst, 32'h1234_52B7);
        drive(5, 8'h6F, 0, 0, 1, 0, 0, 32'h0000_0800);  cycle(); check("t3_j", out_inst, 32'h0010_00EF);
        check("t3_j_addr", out_addr, 32'h10);
        in_valid = 1'b0; cycle();

        // Plan 4: back-pressure with three offered words
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h13, 0, 0, i + 1, 0, 0, 32'(i));
            cycle();
        end
        check("t4_in_ready_full", 32'(in_ready), 32'h0);
        check("t4_head_stable", out_inst, 32'h0000_0093);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        // Plan 5: illegal format, then a legal word at the unadvanced address
        drive(7, 8'h13, 0, 0, 1, 0, 0, 32'h0);
        cycle();
        check("t5_err", 32'(err), 32'h1);
        drive(1, 8'h13, 0, 0, 2, 0, 0, 32'd1);
        cycle();
        check("t5_err_drop", 32'(err), 32'h0);
        check("t5_sticky", 32'(err_sticky), 32'h1);
        drive(1, 8'h13, 0, 0, 1, 0, 0, 32'd2048);       cycle();
        drive(3, 8'h63, 0, 0, 0, 0, 0, 32'd3);          cycle();
        in_valid = 1'b0; cycle();

        // Plan 6: restart with two buffered entries and a pending input
        out_ready = 1'b0;
        drive(0, 8'h33, 0, 0, 1, 2, 3, 32'h0); cycle(); cycle();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_sticky", 32'(err_sticky), 32'h0);
        cycle();
        check("t6_addr", out_addr, BASE);

        // Async reset mid-stream discards buffered words at once
        drive(4, 8'h17, 0, 0, 4, 0, 0, 32'hABCD_E000); cycle();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_addr", out_addr, BASE);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clock); model_edge();
        @(negedge clock); check_outputs();
        drive(0, 8'h33, 0, 0, 7, 7, 7, 32'h0);
        cycle();
        check("arst_next_addr", out_addr, BASE);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            restart   = ($urandom_range(0, 99) < 3);
            in_fmt    = 3'($urandom_range(0, 7));
            in_opcode = 7'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                1:       in_imm = $urandom & 32'hFFFF_F000;
                2:       in_imm = 32'($signed($urandom_range(0, 4194303)) - 2097152);
                default: in_imm = $urandom;
            endcase
            cycle();
        end
        restart = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
